// File: rtl/board_editor_pkg.sv
// board_editor_pkg
//   Shared definitions for the board editing engine and the renderer fetch
//   side: edit opcodes, FSM state encoding, default board geometry and
//   the derived word count.
package board_editor_pkg;

   localparam int DEF_WORD_SIZE      = 16;
   localparam int DEF_LOG_WORD_SIZE  = $clog2(DEF_WORD_SIZE);
   localparam int DEF_LOG_BOARD_SIZE = 6;
   localparam int DEF_NUM_WORDS      = 2 ** (2 * DEF_LOG_BOARD_SIZE - DEF_LOG_WORD_SIZE);
   localparam int DEF_LOG_MAX_ADDR   = $clog2(DEF_NUM_WORDS);

   typedef enum logic [1:0] {
      OP_TOGGLE    = 2'd0,
      OP_SET       = 2'd1,
      OP_CLEAR     = 2'd2,
      OP_CLEAR_ALL = 2'd3
   } edit_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CLEAR = 3'd3,
      ST_DONE  = 3'd4
   } edit_state_t;

   // Words needed to hold a 2^log_board square board at 2^log_word cells/word.
   function automatic int num_words(input int log_board, input int log_word);
      return 2 ** (2 * log_board - log_word);
   endfunction

endpackage

// File: rtl/board_editor_cell_addr_map.sv
// cell_addr_map
//   Combinational mapping of a board coordinate to its packed memory
//   location. Row-major: each row occupies 2^(LOG_BOARD_SIZE-LOG_WORD_SIZE)
//   consecutive words, and the low x bits select the bit within the word.
//   Shared with the renderer fetch path so both sides agree on layout.
// Ports:
//   x, y       cell coordinate
//   word_addr  word address, zero-extended to LOG_MAX_ADDR bits
//   bit_idx    bit position of the cell within that word
module cell_addr_map
   import board_editor_pkg::*;
#(
   parameter int LOG_WORD_SIZE  = DEF_LOG_WORD_SIZE,
   parameter int LOG_BOARD_SIZE = DEF_LOG_BOARD_SIZE,
   parameter int LOG_MAX_ADDR   = DEF_LOG_MAX_ADDR
) (
   input  logic [LOG_BOARD_SIZE-1:0] x,
   input  logic [LOG_BOARD_SIZE-1:0] y,
   output logic [LOG_MAX_ADDR-1:0]   word_addr,
   output logic [LOG_WORD_SIZE-1:0]  bit_idx
);

   assign word_addr = LOG_MAX_ADDR'({y, x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]});
   assign bit_idx   = x[LOG_WORD_SIZE-1:0];

endmodule

// File: rtl/board_editor.sv
// board_editor
//   Read-modify-write engine for the packed board memory. Applies a single
//   cell TOGGLE/SET/CLEAR by reading the containing word, modifying one bit
//   and writing it back, or sweeps every word to zero for CLEAR_ALL.
//   All memory-side outputs are registered.
// Ports:
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   req_valid_in   edit request valid
//   req_ready_out  engine idle; request taken when valid && ready at an edge
//   op_in          edit opcode (edit_op_t)
//   x_in, y_in     cell coordinate (ignored for CLEAR_ALL)
//   addr_out       memory address shared by read and write
//   data_r_in      memory read data
//   data_w_out     memory write data
//   we_out         memory write enable
//   done_out       one-cycle pulse when an operation completes
module board_editor
   import board_editor_pkg::*;
#(
   parameter int WORD_SIZE      = DEF_WORD_SIZE,
   parameter int LOG_WORD_SIZE  = $clog2(WORD_SIZE),
   parameter int LOG_BOARD_SIZE = DEF_LOG_BOARD_SIZE,
   parameter int LOG_MAX_ADDR   = DEF_LOG_MAX_ADDR,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      req_valid_in,
   output logic                      req_ready_out,
   input  edit_op_t                  op_in,
   input  logic [LOG_BOARD_SIZE-1:0] x_in,
   input  logic [LOG_BOARD_SIZE-1:0] y_in,
   output logic [LOG_MAX_ADDR-1:0]   addr_out,
   input  logic [WORD_SIZE-1:0]      data_r_in,
   output logic [WORD_SIZE-1:0]      data_w_out,
   output logic                      we_out,
   output logic                      done_out
);

   localparam int NUM_WORDS = num_words(LOG_BOARD_SIZE, LOG_WORD_SIZE);
   localparam int RC_W      = $clog2(READ_LATENCY + 1);
   localparam logic [RC_W-1:0]         RC_LAST   = RC_W'(READ_LATENCY - 1);
   localparam logic [LOG_MAX_ADDR-1:0] ADDR_LAST = LOG_MAX_ADDR'(NUM_WORDS - 1);

   if (NUM_WORDS > 2 ** LOG_MAX_ADDR) begin : g_addr_width_check
      $error("board_editor: board needs more words than LOG_MAX_ADDR can address");
   end
   if ((2 ** LOG_WORD_SIZE) != WORD_SIZE) begin : g_word_size_check
      $error("board_editor: WORD_SIZE must equal 2**LOG_WORD_SIZE");
   end
   if (READ_LATENCY < 1) begin : g_latency_check
      $error("board_editor: READ_LATENCY must be at least 1");
   end

   // One-bit modification of a fetched word; every other bit passes through.
   function automatic logic [WORD_SIZE-1:0] apply_edit(
      input logic [WORD_SIZE-1:0]     word,
      input logic [LOG_WORD_SIZE-1:0] idx,
      input edit_op_t                 op
   );
      logic [WORD_SIZE-1:0] mask;
      mask = WORD_SIZE'(1) << idx;
      case (op)
         OP_TOGGLE: return word ^ mask;
         OP_SET:    return word | mask;
         default:   return word & ~mask;
      endcase
   endfunction

   edit_state_t               state_q, state_d;
   edit_op_t                  op_q, op_d;
   logic [LOG_WORD_SIZE-1:0]  bit_q, bit_d;
   logic [RC_W-1:0]           rd_cnt_q, rd_cnt_d;
   logic [LOG_MAX_ADDR-1:0]   clr_cnt_q, clr_cnt_d;
   logic [LOG_MAX_ADDR-1:0]   addr_d;
   logic [WORD_SIZE-1:0]      data_w_d;
   logic                      we_d, done_d;
   logic [LOG_MAX_ADDR-1:0]   map_addr;
   logic [LOG_WORD_SIZE-1:0]  map_bit;

   cell_addr_map #(
      .LOG_WORD_SIZE  (LOG_WORD_SIZE),
      .LOG_BOARD_SIZE (LOG_BOARD_SIZE),
      .LOG_MAX_ADDR   (LOG_MAX_ADDR)
   ) u_cell_addr_map (
      .x         (x_in),
      .y         (y_in),
      .word_addr (map_addr),
      .bit_idx   (map_bit)
   );

   assign req_ready_out = (state_q == ST_IDLE);

   // Next-state and next-output logic; outputs are registered below, so the
   // values computed here appear on the ports one cycle later.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      bit_d     = bit_q;
      rd_cnt_d  = rd_cnt_q;
      clr_cnt_d = clr_cnt_q;
      addr_d    = addr_out;
      data_w_d  = data_w_out;
      we_d      = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_in) begin
               op_d = op_in;
               if (op_in == OP_CLEAR_ALL) begin
                  // First clearing write goes out on the very next cycle.
                  state_d   = ST_CLEAR;
                  clr_cnt_d = '0;
                  addr_d    = '0;
                  data_w_d  = '0;
                  we_d      = 1'b1;
               end else begin
                  state_d  = ST_READ;
                  addr_d   = map_addr;
                  bit_d    = map_bit;
                  rd_cnt_d = '0;
               end
            end
         end
         ST_READ: begin
            // Read data is valid on the last READ cycle; modify it in flight
            // so the write is presented directly in the WRITE cycle.
            if (rd_cnt_q == RC_LAST) begin
               state_d  = ST_WRITE;
               data_w_d = apply_edit(data_r_in, bit_q, op_q);
               we_d     = 1'b1;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end
         ST_WRITE: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
         ST_CLEAR: begin
            if (clr_cnt_q == ADDR_LAST) begin
               state_d   = ST_DONE;
               clr_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               addr_d    = clr_cnt_q + 1'b1;
               we_d      = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         rd_cnt_q   <= '0;
         clr_cnt_q  <= '0;
         addr_out   <= '0;
         data_w_out <= '0;
         we_out     <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         clr_cnt_q  <= clr_cnt_d;
         addr_out   <= addr_d;
         data_w_out <= data_w_d;
         we_out     <= we_d;
         done_out   <= done_d;
      end
   end

   // Latched request fields; only meaningful while an operation is active.
   always_ff @(posedge clk_in) begin
      op_q  <= op_d;
      bit_q <= bit_d;
   end

endmodule

// File: tb/tb_board_editor.sv
module tb_board_editor;
   import board_editor_pkg::*;

   localparam int WS  = 16;
   localparam int LBS = 6;
   localparam int LMA = 8;
   localparam int NW  = 256;
   localparam int RL  = 2;
   localparam int WPR = (1 << LBS) / WS;
   localparam int TMO = 600;

   logic           clk_in = 1'b0;
   logic           rst_n_in = 1'b0;
   logic           req_valid_in = 1'b0;
   logic           req_ready_out;
   edit_op_t       op_in = OP_TOGGLE;
   logic [LBS-1:0] x_in = '0;
   logic [LBS-1:0] y_in = '0;
   logic [LMA-1:0] addr_out;
   logic [WS-1:0]  data_r_in;
   logic [WS-1:0]  data_w_out;
   logic           we_out;
   logic           done_out;

   always #5 clk_in = ~clk_in;

   board_editor #(
      .WORD_SIZE(WS), .LOG_WORD_SIZE(4), .LOG_BOARD_SIZE(LBS),
      .LOG_MAX_ADDR(LMA), .READ_LATENCY(RL)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .req_valid_in(req_valid_in),
      .req_ready_out(req_ready_out), .op_in(op_in), .x_in(x_in), .y_in(y_in),
      .addr_out(addr_out), .data_r_in(data_r_in), .data_w_out(data_w_out),
      .we_out(we_out), .done_out(done_out)
   );

   // Board BRAM: address sampled on one edge, data usable by the next one,
   // giving a two-cycle read from address-stable to data-captured.
   logic [WS-1:0]  mem [NW];
   logic [WS-1:0]  rd_p;
   logic           fill_en = 1'b0;
   logic [WS-1:0]  fill_val = '0;
   logic           pre_we = 1'b0;
   logic [LMA-1:0] pre_addr = '0;
   logic [WS-1:0]  pre_data = '0;
   int             cyc = 0;

   always @(posedge clk_in) begin
      cyc  <= cyc + 1;
      rd_p <= mem[addr_out];
      if (fill_en) begin
         for (int i = 0; i < NW; i++) mem[i] <= fill_val;
      end else if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (we_out) begin
         mem[addr_out] <= data_w_out;
      end
   end
   assign data_r_in = rd_p;

   int            wr_addr_q [$];
   logic [WS-1:0] wr_data_q [$];
   int            wr_cyc_q  [$];
   int            done_q    [$];

   always @(negedge clk_in) begin
      if (we_out) begin
         wr_addr_q.push_back(int'(addr_out));
         wr_data_q.push_back(data_w_out);
         wr_cyc_q.push_back(cyc);
      end
      if (done_out) done_q.push_back(cyc);
   end

   logic [WS-1:0] ref_mem [NW];
   int checks = 0;
   int errors = 0;

   function automatic int ref_addr(input int x, input int y);
      return y * WPR + x / WS;
   endfunction

   function automatic logic [WS-1:0] ref_edit(input edit_op_t op, input logic [WS-1:0] w, input int b);
      logic [WS-1:0] r;
      r = w;
      case (op)
         OP_TOGGLE: r[b] = ~w[b];
         OP_SET:    r[b] = 1'b1;
         default:   r[b] = 1'b0;
      endcase
      return r;
   endfunction

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_q.delete();
   endtask

   task automatic fill(input logic [WS-1:0] v);
      @(negedge clk_in); fill_en = 1'b1; fill_val = v;
      @(negedge clk_in); fill_en = 1'b0;
      for (int i = 0; i < NW; i++) ref_mem[i] = v;
   endtask

   task automatic preload(input int a, input logic [WS-1:0] v);
      @(negedge clk_in); pre_we = 1'b1; pre_addr = LMA'(a); pre_data = v;
      @(negedge clk_in); pre_we = 1'b0;
      ref_mem[a] = v;
   endtask

   // Issues one request, scrambles the request inputs right after
   // acceptance, and waits (bounded) for the done pulse.
   task automatic run_op(input edit_op_t op, input int x, input int y,
                         output int t_acc, output int t_done, output int rdy_busy, output bit ok);
      int n;
      ok = 1'b1; rdy_busy = 0; t_acc = -1; t_done = -1;
      @(negedge clk_in);
      req_valid_in = 1'b1; op_in = op; x_in = LBS'(x); y_in = LBS'(y);
      n = 0;
      while (!req_ready_out && n < TMO) begin @(negedge clk_in); n++; end
      if (!req_ready_out) begin ok = 1'b0; req_valid_in = 1'b0; return; end
      @(posedge clk_in); #1; t_acc = cyc;
      @(negedge clk_in);
      req_valid_in = 1'b0;
      op_in = edit_op_t'($urandom_range(0, 3));
      x_in = LBS'($urandom); y_in = LBS'($urandom);
      n = 0;
      while (!done_out && n < TMO) begin
         if (req_ready_out) rdy_busy++;
         @(negedge clk_in); n++;
      end
      if (done_out) t_done = cyc; else ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++; if (addr_out !== '0)   begin errors++; $display("FAIL reset_addr got %h want 0", addr_out); end
      checks++; if (data_w_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_w_out); end
      checks++; if (we_out !== 1'b0)   begin errors++; $display("FAIL reset_we got %b want 0", we_out); end
      checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_out); end
      rst_n_in = 1'b1;
      @(negedge clk_in);
      checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_out); end
   endtask

   task automatic test_toggle();
      int xs[8], ys[8];
      int ta, td, rb, ea; bit ok; logic [WS-1:0] ed;
      preload(9, 16'h0000);
      xs[0] = 17; ys[0] = 2; xs[1] = 17; ys[1] = 2;
      for (int i = 2; i < 8; i++) begin xs[i] = $urandom_range(0, 63); ys[i] = $urandom_range(0, 63); end
      for (int i = 0; i < 8; i++) begin
         ea = ref_addr(xs[i], ys[i]);
         ed = ref_edit(OP_TOGGLE, ref_mem[ea], xs[i] % WS);
         clear_logs();
         run_op(OP_TOGGLE, xs[i], ys[i], ta, td, rb, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL toggle_timeout op %0d acc %0d done %0d", i, ta, td); end
         else begin
            checks++; if (td !== ta + RL + 1) begin errors++; $display("FAIL toggle_done_time op %0d got %0d want %0d", i, td, ta + RL + 1); end
            checks++; if (rb !== 0) begin errors++; $display("FAIL toggle_ready_busy op %0d got %0d want 0", i, rb); end
            checks++;
            if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL toggle_write_count op %0d got %0d want 1", i, wr_addr_q.size()); end
            else begin
               checks++; if (wr_addr_q[0] !== ea) begin errors++; $display("FAIL toggle_addr op %0d got %0d want %0d", i, wr_addr_q[0], ea); end
               checks++; if (wr_data_q[0] !== ed) begin errors++; $display("FAIL toggle_data op %0d got %h want %h", i, wr_data_q[0], ed); end
               checks++; if (wr_cyc_q[0] !== ta + RL) begin errors++; $display("FAIL toggle_write_time op %0d got %0d want %0d", i, wr_cyc_q[0], ta + RL); end
            end
         end
         ref_mem[ea] = ed;
         if (i == 0) begin
            checks++; if (ed !== 16'h0002) begin errors++; $display("FAIL toggle_first_value got %h want 0002", ed); end
         end
      end
   endtask

   task automatic test_set_clear();
      edit_op_t ops[8]; int xs[8], ys[8];
      int ta, td, rb, ea; bit ok; logic [WS-1:0] ed;
      preload(255, 16'h8001);
      ops[0] = OP_SET; xs[0] = 63; ys[0] = 63;
      ops[1] = OP_CLEAR; xs[1] = 63; ys[1] = 63;
      for (int i = 2; i < 8; i++) begin
         ops[i] = ($urandom_range(0, 1) == 0) ? OP_SET : OP_CLEAR;
         xs[i] = $urandom_range(0, 63); ys[i] = $urandom_range(0, 63);
      end
      for (int i = 0; i < 8; i++) begin
         ea = ref_addr(xs[i], ys[i]);
         ed = ref_edit(ops[i], ref_mem[ea], xs[i] % WS);
         clear_logs();
         run_op(ops[i], xs[i], ys[i], ta, td, rb, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL setclr_timeout op %0d acc %0d done %0d", i, ta, td); end
         else begin
            checks++; if (td !== ta + RL + 1) begin errors++; $display("FAIL setclr_done_time op %0d got %0d want %0d", i, td, ta + RL + 1); end
            checks++;
            if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL setclr_write_count op %0d got %0d want 1", i, wr_addr_q.size()); end
            else begin
               checks++; if (wr_addr_q[0] !== ea) begin errors++; $display("FAIL setclr_addr op %0d got %0d want %0d", i, wr_addr_q[0], ea); end
               checks++; if (wr_data_q[0] !== ed) begin errors++; $display("FAIL setclr_data op %0d got %h want %h", i, wr_data_q[0], ed); end
            end
         end
         ref_mem[ea] = ed;
      end
      checks++; if (ref_mem[255] !== 16'h0001) begin errors++; $display("FAIL setclr_word255 got %h want 0001", ref_mem[255]); end
      checks++; if (mem[255] !== ref_mem[255]) begin errors++; $display("FAIL setclr_readback got %h want %h", mem[255], ref_mem[255]); end
   endtask

   task automatic test_clear_all();
      int ta, td, rb, bad, nz; bit ok;
      fill(16'hFFFF);
      clear_logs();
      run_op(OP_CLEAR_ALL, $urandom_range(0, 63), $urandom_range(0, 63), ta, td, rb, ok);
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      checks++;
      if (!ok) begin errors++; $display("FAIL clrall_timeout acc %0d done %0d", ta, td); end
      else begin
         checks++; if (td !== ta + NW) begin errors++; $display("FAIL clrall_done_time got %0d want %0d", td, ta + NW); end
         checks++; if (rb !== 0) begin errors++; $display("FAIL clrall_ready_busy got %0d want 0", rb); end
         checks++;
         if (wr_addr_q.size() !== NW) begin errors++; $display("FAIL clrall_write_count got %0d want %0d", wr_addr_q.size(), NW); end
         else begin
            bad = 0;
            for (int k = 0; k < NW; k++)
               if (wr_addr_q[k] != k || wr_data_q[k] != '0 || wr_cyc_q[k] != ta + k) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL clrall_sequence got %0d bad writes want 0", bad); end
         end
      end
      @(negedge clk_in);
      nz = 0;
      for (int k = 0; k < NW; k++) if (mem[k] !== ref_mem[k]) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL clrall_readback got %0d nonzero words want 0", nz); end
   endtask

   task automatic test_back_to_back();
      int xs[3], ys[3], ea[3], acc[3];
      logic [WS-1:0] ed[3];
      int k, n;
      for (int i = 0; i < 3; i++) begin
         xs[i] = $urandom_range(0, 63); ys[i] = $urandom_range(0, 63);
         ea[i] = ref_addr(xs[i], ys[i]);
         ed[i] = ref_edit(OP_TOGGLE, ref_mem[ea[i]], xs[i] % WS);
         ref_mem[ea[i]] = ed[i];
      end
      clear_logs();
      @(negedge clk_in);
      req_valid_in = 1'b1; op_in = OP_TOGGLE; x_in = LBS'(xs[0]); y_in = LBS'(ys[0]);
      k = 0; n = 0;
      while (k < 3 && n < 100) begin
         if (req_ready_out) begin
            @(posedge clk_in); #1; acc[k] = cyc; k++;
            @(negedge clk_in);
            if (k < 3) begin x_in = LBS'(xs[k]); y_in = LBS'(ys[k]); end
            else req_valid_in = 1'b0;
         end else begin
            @(negedge clk_in);
         end
         n++;
      end
      req_valid_in = 1'b0;
      n = 0;
      while (done_q.size() < 3 && n < 50) begin @(negedge clk_in); n++; end
      checks++;
      if (k !== 3 || done_q.size() !== 3) begin errors++; $display("FAIL b2b_done_count got %0d accepts %0d dones want 3", k, done_q.size()); end
      else begin
         checks++; if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5) begin errors++; $display("FAIL b2b_accept_spacing got %0d %0d want 5 5", acc[1] - acc[0], acc[2] - acc[1]); end
         checks++; if (done_q[1] - done_q[0] !== 5 || done_q[2] - done_q[1] !== 5) begin errors++; $display("FAIL b2b_done_spacing got %0d %0d want 5 5", done_q[1] - done_q[0], done_q[2] - done_q[1]); end
         checks++;
         if (wr_addr_q.size() !== 3) begin errors++; $display("FAIL b2b_write_count got %0d want 3", wr_addr_q.size()); end
         else begin
            for (int i = 0; i < 3; i++) begin
               checks++; if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin errors++; $display("FAIL b2b_write op %0d got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int ta, td, rb, n, ea; bit ok; logic [WS-1:0] ed;
      ea = ref_addr(5, 5);
      clear_logs();
      @(negedge clk_in);
      req_valid_in = 1'b1; op_in = OP_TOGGLE; x_in = LBS'(5); y_in = LBS'(5);
      n = 0;
      while (!req_ready_out && n < TMO) begin @(negedge clk_in); n++; end
      @(posedge clk_in);
      @(negedge clk_in);
      req_valid_in = 1'b0;
      rst_n_in = 1'b0;
      #1;
      checks++; if (addr_out !== '0 || data_w_out !== '0 || we_out !== 1'b0 || done_out !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs got addr %h data %h we %b done %b want all 0", addr_out, data_w_out, we_out, done_out); end
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (6) @(negedge clk_in);
      checks++; if (wr_addr_q.size() !== 0 || done_q.size() !== 0) begin errors++; $display("FAIL midrst_activity got %0d writes %0d dones want 0 0", wr_addr_q.size(), done_q.size()); end
      checks++; if (mem[ea] !== ref_mem[ea]) begin errors++; $display("FAIL midrst_mem got %h want %h", mem[ea], ref_mem[ea]); end
      checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", req_ready_out); end
      ed = ref_edit(OP_TOGGLE, ref_mem[ea], 5);
      clear_logs();
      run_op(OP_TOGGLE, 5, 5, ta, td, rb, ok);
      checks++;
      if (!ok || wr_addr_q.size() !== 1) begin errors++; $display("FAIL midrst_next_op got ok %0d writes %0d want 1 1", ok, wr_addr_q.size()); end
      else begin
         checks++; if (wr_addr_q[0] !== ea || wr_data_q[0] !== ed) begin errors++; $display("FAIL midrst_next_write got %0d/%h want %0d/%h", wr_addr_q[0], wr_data_q[0], ea, ed); end
      end
      ref_mem[ea] = ed;
   endtask

   task automatic test_busy_during_clear();
      int ta, ta2, n, tx, ty, ea, nz; logic [WS-1:0] ed;
      fill(16'hA5A5);
      tx = $urandom_range(0, 63); ty = $urandom_range(0, 63);
      ea = ref_addr(tx, ty);
      clear_logs();
      @(negedge clk_in);
      req_valid_in = 1'b1; op_in = OP_CLEAR_ALL;
      n = 0;
      while (!req_ready_out && n < TMO) begin @(negedge clk_in); n++; end
      @(posedge clk_in); #1; ta = cyc;
      @(negedge clk_in);
      op_in = OP_TOGGLE; x_in = LBS'(tx); y_in = LBS'(ty);
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      ed = ref_edit(OP_TOGGLE, ref_mem[ea], tx % WS);
      n = 0;
      while (!req_ready_out && n < TMO) begin @(negedge clk_in); n++; end
      @(posedge clk_in); #1; ta2 = cyc;
      @(negedge clk_in);
      req_valid_in = 1'b0; x_in = LBS'(tx + 1 + $urandom_range(0, 30)); y_in = LBS'(ty + 7);
      n = 0;
      while (done_q.size() < 2 && n < TMO) begin @(negedge clk_in); n++; end
      checks++; if (ta2 !== ta + NW + 2) begin errors++; $display("FAIL busy_accept_time got %0d want %0d", ta2, ta + NW + 2); end
      checks++;
      if (wr_addr_q.size() !== NW + 1) begin errors++; $display("FAIL busy_write_count got %0d want %0d", wr_addr_q.size(), NW + 1); end
      else begin
         checks++; if (wr_addr_q[NW] !== ea || wr_data_q[NW] !== ed) begin errors++; $display("FAIL busy_latched_write got %0d/%h want %0d/%h", wr_addr_q[NW], wr_data_q[NW], ea, ed); end
      end
      ref_mem[ea] = ed;
      @(negedge clk_in);
      nz = 0;
      for (int k = 0; k < NW; k++) if (mem[k] !== ref_mem[k]) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL busy_readback got %0d differing words want 0", nz); end
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_set_clear();
      test_clear_all();
      test_back_to_back();
      test_reset_mid_op();
      test_busy_during_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete at time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
